// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage plus MEM/WB register.
// Runs one data-memory access at a time over req/ack, stalls upstream while it
// is outstanding, aborts after TIMEOUT_CYCLES busy cycles, and registers the
// selected write-back data for the WB stage.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] alu_res,
  input  logic [31:0] wr_data,
  input  logic [4:0]  dest_reg,
  input  logic [31:0] pc_4,
  mem_stage_if.master dm,
  output logic        stall,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dest_reg,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wb_reg_write_q, wb_reg_write_d;
  logic [4:0]    wb_dest_reg_q, wb_dest_reg_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          misalign_q, misalign_d;
  logic          timeout_q, timeout_d;
  logic          stall_c;
  logic          acc;
  logic          aligned;

  // Next-state, capture and MEM/WB selection; the WB enable is only raised
  // when an instruction actually retires from this stage.
  always_comb begin
    acc            = mem_read | mem_write;
    aligned        = (alu_res[1:0] == 2'b00);
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    rdata_d        = rdata_q;
    stall_c        = 1'b0;
    misalign_d     = 1'b0;
    timeout_d      = timeout_q;
    wb_reg_write_d = 1'b0;
    wb_dest_reg_d  = dest_reg;
    case (mem_to_reg)
      2'b01:   wb_data_d = rdata_q;
      2'b10:   wb_data_d = pc_4;
      default: wb_data_d = alu_res;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!acc) begin
          wb_reg_write_d = reg_write;
        end else if (!aligned) begin
          misalign_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          addr_d  = alu_res;
          wdata_d = wr_data;
          we_d    = mem_write;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        if (dm.dm_ack) begin
          rdata_d = dm.dm_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          rdata_d   = 32'h0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        wb_reg_write_d = reg_write;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and MEM/WB register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      we_q           <= 1'b0;
      rdata_q        <= 32'h0;
      wb_reg_write_q <= 1'b0;
      wb_dest_reg_q  <= 5'h0;
      wb_data_q      <= 32'h0;
      misalign_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      rdata_q        <= rdata_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_dest_reg_q  <= wb_dest_reg_d;
      wb_data_q      <= wb_data_d;
      misalign_q     <= misalign_d;
      timeout_q      <= timeout_d;
    end
  end

  // Bus fields are forced to zero whenever no request is presented.
  always_comb begin
    dm.dm_req    = (state_q == S_BUSY);
    dm.dm_we     = (state_q == S_BUSY) ? we_q : 1'b0;
    dm.dm_addr   = (state_q == S_BUSY) ? addr_q : 32'h0;
    dm.dm_wdata  = (state_q == S_BUSY) ? wdata_q : 32'h0;
    stall        = stall_c;
    wb_reg_write = wb_reg_write_q;
    wb_dest_reg  = wb_dest_reg_q;
    wb_data      = wb_data_q;
    misalign_err = misalign_q;
    timeout_err  = timeout_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: two instances (default timeout and timeout=4),
// a transaction-level expectation queue checked every cycle, plus literal pins.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  m2r;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  dst;
    logic [31:0] pc4;
  } ex_t;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wbw;
    logic [4:0]  wbd;
    logic [31:0] wbdata;
    logic        mis;
    logic        tmo;
  } obs_t;

  typedef struct {
    int   sel;
    obs_t o;
    logic chk_data;
  } rec_t;

  localparam ex_t NOP = '0;

  ex_t ex_a, ex_b;
  mem_stage_if bus_a ();
  mem_stage_if bus_b ();

  logic        stall_a, wbw_a, mis_a, tmo_a;
  logic [4:0]  wbd_a;
  logic [31:0] wbdata_a;
  logic        stall_b, wbw_b, mis_b, tmo_b;
  logic [4:0]  wbd_b;
  logic [31:0] wbdata_b;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst),
    .mem_read(ex_a.rd), .mem_write(ex_a.wr), .mem_to_reg(ex_a.m2r),
    .reg_write(ex_a.rw), .alu_res(ex_a.alu), .wr_data(ex_a.wd),
    .dest_reg(ex_a.dst), .pc_4(ex_a.pc4),
    .dm(bus_a.master),
    .stall(stall_a), .wb_reg_write(wbw_a), .wb_dest_reg(wbd_a),
    .wb_data(wbdata_a), .misalign_err(mis_a), .timeout_err(tmo_a)
  );

  mem_stage #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst),
    .mem_read(ex_b.rd), .mem_write(ex_b.wr), .mem_to_reg(ex_b.m2r),
    .reg_write(ex_b.rw), .alu_res(ex_b.alu), .wr_data(ex_b.wd),
    .dest_reg(ex_b.dst), .pc_4(ex_b.pc4),
    .dm(bus_b.master),
    .stall(stall_b), .wb_reg_write(wbw_b), .wb_dest_reg(wbd_b),
    .wb_data(wbdata_b), .misalign_err(mis_b), .timeout_err(tmo_b)
  );

  obs_t oa, ob;
  always_comb begin
    oa = {stall_a, bus_a.dm_req, bus_a.dm_we, bus_a.dm_addr, bus_a.dm_wdata,
          wbw_a, wbd_a, wbdata_a, mis_a, tmo_a};
    ob = {stall_b, bus_b.dm_req, bus_b.dm_we, bus_b.dm_addr, bus_b.dm_wdata,
          wbw_b, wbd_b, wbdata_b, mis_b, tmo_b};
  end

  int total = 0;
  int bad = 0;
  int stall_seen, req_seen, mis_seen;
  rec_t q[$];

  // Model of the registered outputs visible in the upcoming cycle, per DUT.
  logic        m_wbw[2];
  logic [4:0]  m_wbd[2];
  logic [31:0] m_wbdata[2];
  logic        m_known[2];
  logic        m_mis[2];
  logic        m_tmo[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_sel(input ex_t e, input logic [31:0] memv);
    case (e.m2r)
      2'b01:   return memv;
      2'b10:   return e.pc4;
      default: return e.alu;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_wbw[i] = 1'b0; m_wbd[i] = 5'h0; m_wbdata[i] = 32'h0;
      m_known[i] = 1'b1; m_mis[i] = 1'b0; m_tmo[i] = 1'b0;
    end
  endtask

  task automatic model_wb(input int sel, input logic w, input logic [4:0] d,
                          input logic [31:0] data, input logic known, input logic mis);
    m_wbw[sel] = w; m_wbd[sel] = d; m_wbdata[sel] = data;
    m_known[sel] = known; m_mis[sel] = mis;
  endtask

  // One clock cycle: drive inputs, queue the outputs expected during it.
  task automatic step(input int sel, input ex_t e, input logic ack, input logic [31:0] rdv,
                      input logic r, input logic xs, input logic xq, input logic xw,
                      input logic [31:0] xa, input logic [31:0] xd);
    rec_t t;
    int o;
    @(posedge clk); #1;
    rst = r;
    if (sel == 0) begin
      ex_a = e; ex_b = NOP;
      bus_a.dm_ack = ack; bus_a.dm_rdata = rdv;
      bus_b.dm_ack = 1'b0; bus_b.dm_rdata = 32'h0;
    end else begin
      ex_b = e; ex_a = NOP;
      bus_b.dm_ack = ack; bus_b.dm_rdata = rdv;
      bus_a.dm_ack = 1'b0; bus_a.dm_rdata = 32'h0;
    end
    t.sel = sel;
    t.o = {xs, xq, xw, xa, xd, m_wbw[sel], m_wbd[sel], m_wbdata[sel], m_mis[sel], m_tmo[sel]};
    t.chk_data = m_known[sel];
    q.push_back(t);
    o = 1 - sel;
    model_wb(o, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0);
  endtask

  // Whole instruction at transaction level. ack_at: BUSY cycle number carrying
  // the ack (-1 = never). rst_at: BUSY cycle in which reset is applied (0 = none).
  task automatic run(input int sel, input ex_t e, input int ack_at,
                     input logic [31:0] rdv, input int rst_at);
    int tmo_lim;
    int k;
    logic a, r, fin, timed;
    logic [31:0] memv;
    tmo_lim = (sel == 0) ? 16 : 4;
    if (!(e.rd | e.wr)) begin
      step(sel, e, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      model_wb(sel, e.rw, e.dst, wb_sel(e, 32'h0), e.m2r != 2'b01, 1'b0);
      return;
    end
    if (e.alu[1:0] != 2'b00) begin
      step(sel, e, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      model_wb(sel, 1'b0, e.dst, 32'h0, 1'b0, 1'b1);
      return;
    end
    step(sel, e, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_wb(sel, 1'b0, e.dst, 32'h0, 1'b0, 1'b0);
    fin = 1'b0; timed = 1'b0; memv = 32'h0; k = 1;
    while (!fin) begin
      a = (k == ack_at);
      r = (k == rst_at);
      step(sel, e, a, a ? rdv : 32'hBAD0BAD0, r, 1'b1, 1'b1, e.wr, e.alu, e.wd);
      if (r) begin
        model_clear();
        return;
      end
      model_wb(sel, 1'b0, e.dst, 32'h0, 1'b0, 1'b0);
      if (a) begin
        memv = rdv; fin = 1'b1;
      end else if (k == tmo_lim) begin
        timed = 1'b1; fin = 1'b1;
      end
      k++;
    end
    if (timed) m_tmo[sel] = 1'b1;
    // A stray ack during the retire cycle must be ignored.
    step(sel, e, 1'b1, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_wb(sel, e.rw, e.dst, wb_sel(e, memv), 1'b1, 1'b0);
  endtask

  task automatic begin_test();
    @(negedge clk); #1;
    stall_seen = 0; req_seen = 0; mis_seen = 0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Per-cycle compare of the selected DUT against the queued expectation.
  rec_t cr;
  obs_t co;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cr = q.pop_front();
      co = (cr.sel == 0) ? oa : ob;
      chk("stall", {31'h0, co.stall}, {31'h0, cr.o.stall});
      chk("dm_req", {31'h0, co.req}, {31'h0, cr.o.req});
      chk("dm_we", {31'h0, co.we}, {31'h0, cr.o.we});
      chk("dm_addr", co.addr, cr.o.addr);
      chk("dm_wdata", co.wdata, cr.o.wdata);
      chk("wb_reg_write", {31'h0, co.wbw}, {31'h0, cr.o.wbw});
      chk("wb_dest_reg", {27'h0, co.wbd}, {27'h0, cr.o.wbd});
      if (cr.chk_data) chk("wb_data", co.wbdata, cr.o.wbdata);
      chk("misalign_err", {31'h0, co.mis}, {31'h0, cr.o.mis});
      chk("timeout_err", {31'h0, co.tmo}, {31'h0, cr.o.tmo});
      if (co.stall === 1'b1) stall_seen++;
      if (co.req === 1'b1) req_seen++;
      if (co.mis === 1'b1) mis_seen++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  ex_t e;
  initial begin
    rst = 1'b1;
    ex_a = NOP; ex_b = NOP;
    bus_a.dm_ack = 1'b0; bus_a.dm_rdata = 32'h0;
    bus_b.dm_ack = 1'b0; bus_b.dm_rdata = 32'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on both instances.
    run(0, NOP, 0, 32'h0, 0);
    run(1, NOP, 0, 32'h0, 0);

    // 1: add -> one-cycle latency, never stalls.
    begin_test();
    e = NOP; e.rw = 1'b1; e.alu = 32'h10; e.dst = 5'd5;
    run(0, e, 0, 32'h0, 0);
    run(0, NOP, 0, 32'h0, 0);
    settle();
    chk("t1_wb_data", wbdata_a, 32'h10);
    chk("t1_wb_dest", {27'h0, wbd_a}, 32'd5);
    chk("t1_wb_we", {31'h0, wbw_a}, 32'd1);
    chk("t1_stall_cycles", stall_seen, 0);

    // 2: lw acked in the first request cycle.
    begin_test();
    e = NOP; e.rd = 1'b1; e.rw = 1'b1; e.m2r = 2'b01; e.alu = 32'h40; e.dst = 5'd7;
    run(0, e, 1, 32'hDEADBEEF, 0);
    run(0, NOP, 0, 32'h0, 0);
    settle();
    chk("t2_stall_cycles", stall_seen, 2);
    chk("t2_req_cycles", req_seen, 1);
    chk("t2_wb_data", wbdata_a, 32'hDEADBEEF);
    chk("t2_wb_we", {31'h0, wbw_a}, 32'd1);

    // 3: sw acked after 5 request cycles.
    begin_test();
    e = NOP; e.wr = 1'b1; e.alu = 32'h44; e.wd = 32'h1234; e.dst = 5'd3;
    run(0, e, 5, 32'h0, 0);
    run(0, NOP, 0, 32'h0, 0);
    settle();
    chk("t3_stall_cycles", stall_seen, 6);
    chk("t3_req_cycles", req_seen, 5);
    chk("t3_wb_we", {31'h0, wbw_a}, 32'd0);

    // 4: misaligned lw dropped with a one-cycle error pulse.
    begin_test();
    e = NOP; e.rd = 1'b1; e.rw = 1'b1; e.m2r = 2'b01; e.alu = 32'h41; e.dst = 5'd8;
    run(0, e, 0, 32'h0, 0);
    run(0, NOP, 0, 32'h0, 0);
    settle();
    chk("t4_wb_we", {31'h0, wbw_a}, 32'd0);
    chk("t4_misalign_now", {31'h0, mis_a}, 32'd1);
    run(0, NOP, 0, 32'h0, 0);
    settle();
    chk("t4_misalign_cycles", mis_seen, 1);
    chk("t4_stall_cycles", stall_seen, 0);
    chk("t4_req_cycles", req_seen, 0);

    // Extra patterns: select 11 acts as ALU, misaligned store, read+write -> write.
    e = NOP; e.rw = 1'b1; e.m2r = 2'b11; e.alu = 32'h55AA; e.dst = 5'd12; e.pc4 = 32'h77;
    run(0, e, 0, 32'h0, 0);
    e = NOP; e.wr = 1'b1; e.alu = 32'h4A; e.wd = 32'h9; e.dst = 5'd2;
    run(0, e, 0, 32'h0, 0);
    e = NOP; e.rd = 1'b1; e.wr = 1'b1; e.alu = 32'h48; e.wd = 32'hA5A5A5A5; e.dst = 5'd6;
    run(0, e, 2, 32'h13579BDF, 0);
    run(0, NOP, 0, 32'h0, 0);

    // 5a: timeout=4 instance, ack exactly on the 4th request cycle -> no error.
    begin_test();
    e = NOP; e.rd = 1'b1; e.rw = 1'b1; e.m2r = 2'b01; e.alu = 32'h80; e.dst = 5'd9;
    run(1, e, 4, 32'hCAFE0001, 0);
    run(1, NOP, 0, 32'h0, 0);
    settle();
    chk("t5a_req_cycles", req_seen, 4);
    chk("t5a_timeout", {31'h0, tmo_b}, 32'd0);
    chk("t5a_wb_data", wbdata_b, 32'hCAFE0001);

    // 5b: no ack -> aborted after 4 request cycles, sticky error, zero data.
    begin_test();
    e = NOP; e.rd = 1'b1; e.rw = 1'b1; e.m2r = 2'b01; e.alu = 32'h84; e.dst = 5'd10;
    run(1, e, -1, 32'h0, 0);
    run(1, NOP, 0, 32'h0, 0);
    settle();
    chk("t5b_req_cycles", req_seen, 4);
    chk("t5b_timeout", {31'h0, tmo_b}, 32'd1);
    chk("t5b_wb_data", wbdata_b, 32'h0);
    chk("t5b_wb_we", {31'h0, wbw_b}, 32'd1);
    repeat (3) run(1, NOP, 0, 32'h0, 0);
    settle();
    chk("t5b_timeout_sticky", {31'h0, tmo_b}, 32'd1);

    // 6: reset on the 2nd BUSY cycle, then a jal.
    begin_test();
    e = NOP; e.rd = 1'b1; e.rw = 1'b1; e.m2r = 2'b01; e.alu = 32'h40; e.dst = 5'd4;
    run(0, e, -1, 32'h0, 2);
    run(0, NOP, 0, 32'h0, 0);
    settle();
    chk("t6_req_after_rst", {31'h0, bus_a.dm_req}, 32'd0);
    chk("t6_stall_after_rst", {31'h0, stall_a}, 32'd0);
    chk("t6_wb_data_rst", wbdata_a, 32'h0);
    chk("t6_wb_dest_rst", {27'h0, wbd_a}, 32'h0);
    chk("t6_timeout_b_rst", {31'h0, tmo_b}, 32'd0);
    e = NOP; e.rw = 1'b1; e.m2r = 2'b10; e.pc4 = 32'h104; e.alu = 32'h999; e.dst = 5'd31;
    run(0, e, 0, 32'h0, 0);
    run(0, NOP, 0, 32'h0, 0);
    settle();
    chk("t6_jal_wb_data", wbdata_a, 32'h104);
    chk("t6_jal_wb_dest", {27'h0, wbd_a}, 32'd31);

    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
